// File: rtl/wait_state_ram_pkg.sv
// rtl/wait_state_ram_pkg.sv - shared constants and state encoding for wait_state_ram
package wait_state_ram_pkg;

   localparam int BUS_W = 32;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/word_store.sv
// rtl/word_store.sv - single-port word array with a registered, clearable read port
module word_store
   import wait_state_ram_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic             re,
   input  logic             clr,
   input  logic             in_range,
   input  logic [AW-1:0]    idx,
   input  logic [BUS_W-1:0] wdata,
   output logic [BUS_W-1:0] rdata
);

   // Storage is deliberately left out of reset so a preload survives it.
   logic [BUS_W-1:0] mem [0:DEPTH_WORDS-1];

   // Write port: out-of-range indices are dropped rather than aliased.
   always_ff @(posedge clock) begin
      if (we && in_range) begin
         mem[idx] <= wdata;
      end
   end

   // Read register: loads on a read, returns zero out of range, cleared on handshake end.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= in_range ? mem[idx] : '0;
      end else if (clr) begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/wait_state_ram.sv
// rtl/wait_state_ram.sv - CPU bus responder RAM with programmable wait states
module wait_state_ram
   import wait_state_ram_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int CNT_W       = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        enable,
   input  logic        read_or_write,
   output logic [31:0] read_data,
   output logic        ready
);

   localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [29:0]        lat_idx;
   logic [BUS_W-1:0]   lat_wdata;
   logic               lat_rw;

   logic               in_range;
   logic               fire;
   logic               st_we;
   logic               st_re;
   logic               st_clr;
   logic               unused_addr_bits;

   // Byte-offset bits carry no meaning on a word-addressed store.
   assign unused_addr_bits = ^addr[1:0];

   // Access strobes derived from the latched request and the wait counter.
   always_comb begin
      in_range = (lat_idx < DEPTH_IDX);
      fire     = (state == BUSY) && enable && (cnt == '0);
      st_we    = fire && (lat_rw == RW_WRITE);
      st_re    = fire && (lat_rw == RW_READ);
      st_clr   = (state == DONE) && !enable;
   end

   // Request FSM: capture, count down wait states, complete, then wait for enable to drop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_rw    <= RW_WRITE;
         ready     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready <= 1'b0;
               if (enable) begin
                  lat_idx   <= addr[31:2];
                  lat_wdata <= write_data;
                  lat_rw    <= read_or_write;
                  cnt       <= CNT_W'(LATENCY);
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (!enable) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  ready <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               if (!enable) begin
                  ready <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               ready <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   word_store #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_store (
      .clock    (clock),
      .reset    (reset),
      .we       (st_we),
      .re       (st_re),
      .clr      (st_clr),
      .in_range (in_range),
      .idx      (lat_idx[AW-1:0]),
      .wdata    (lat_wdata),
      .rdata    (read_data)
   );

endmodule

// File: tb/tb_wait_state_ram.sv
// tb/tb_wait_state_ram.sv - directed self-checking bench for wait_state_ram
module tb_wait_state_ram;

   logic        clock;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        read_or_write;
   logic        en2, en0;
   logic [31:0] rd2, rd0;
   logic        rdy2, rdy0;

   int tests_run    = 0;
   int tests_failed = 0;

   wait_state_ram #(.DEPTH_WORDS(1024), .LATENCY(2), .CNT_W(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .addr          (addr),
      .write_data    (write_data),
      .enable        (en2),
      .read_or_write (read_or_write),
      .read_data     (rd2),
      .ready         (rdy2)
   );

   wait_state_ram #(.DEPTH_WORDS(1024), .LATENCY(0), .CNT_W(4)) dut0 (
      .clock         (clock),
      .reset         (reset),
      .addr          (addr),
      .write_data    (write_data),
      .enable        (en0),
      .read_or_write (read_or_write),
      .read_data     (rd0),
      .ready         (rdy0)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Runs one four-phase transaction; caller is just after a rising edge.
   task automatic run_txn(input bit use0, input logic rw_i, input logic [31:0] a,
                          input logic [31:0] d, output int cycles, output logic [31:0] data,
                          output logic post_rdy, output logic [31:0] post_rd);
      bit seen;
      addr = a;
      write_data = d;
      read_or_write = rw_i;
      if (use0) en0 = 1'b1; else en2 = 1'b1;
      @(posedge clock); #1;
      cycles = -1;
      data = '0;
      seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(posedge clock); #1;
         if ((use0 ? rdy0 : rdy2) === 1'b1) begin
            seen = 1'b1;
            cycles = i;
            data = use0 ? rd0 : rd2;
         end
      end
      if (use0) en0 = 1'b0; else en2 = 1'b0;
      @(posedge clock); #1;
      post_rdy = use0 ? rdy0 : rdy2;
      post_rd = use0 ? rd0 : rd2;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      #1;
      tests_run++; if (rdy2 !== 1'b0) begin tests_failed++; $display("FAIL reset_ready2: got %b expected 0", rdy2); end
      tests_run++; if (rd2 !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata2: got %h expected 00000000", rd2); end
      tests_run++; if (rdy0 !== 1'b0) begin tests_failed++; $display("FAIL reset_ready0: got %b expected 0", rdy0); end
      tests_run++; if (rd0 !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata0: got %h expected 00000000", rd0); end
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_preload;
      int cyc; logic [31:0] d, prd; logic prdy;
      run_txn(0, 1'b0, 32'h10, 32'hDEADBEEF, cyc, d, prdy, prd);
      tests_run++; if (cyc !== 3) begin tests_failed++; $display("FAIL preload_w10_cycles: got %0d expected 3", cyc); end
      run_txn(0, 1'b0, 32'h0, 32'hA5A50000, cyc, d, prdy, prd);
      tests_run++; if (cyc !== 3) begin tests_failed++; $display("FAIL preload_w0_cycles: got %0d expected 3", cyc); end
      tests_run++; if (prdy !== 1'b0) begin tests_failed++; $display("FAIL preload_post_ready: got %b expected 0", prdy); end
   endtask

   task automatic test_read_latency;
      int cyc;
      addr = 32'h10; read_or_write = 1'b1; en2 = 1'b1;
      @(posedge clock); #1;
      cyc = -1;
      for (int i = 1; i <= 40 && cyc < 0; i++) begin
         @(posedge clock); #1;
         if (rdy2 === 1'b1) cyc = i;
      end
      tests_run++; if (cyc !== 3) begin tests_failed++; $display("FAIL read_cycles: got %0d expected 3", cyc); end
      tests_run++; if (rd2 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL read_data: got %h expected deadbeef", rd2); end
      addr = 32'h20;
      @(posedge clock); #1;
      tests_run++; if (rdy2 !== 1'b1) begin tests_failed++; $display("FAIL done_hold_ready: got %b expected 1", rdy2); end
      tests_run++; if (rd2 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL done_hold_data: got %h expected deadbeef", rd2); end
      en2 = 1'b0;
      @(posedge clock); #1;
      tests_run++; if (rdy2 !== 1'b0) begin tests_failed++; $display("FAIL read_drop_ready: got %b expected 0", rdy2); end
      tests_run++; if (rd2 !== 32'h0) begin tests_failed++; $display("FAIL read_drop_data: got %h expected 00000000", rd2); end
   endtask

   task automatic test_write_read_low_bits;
      int cyc; logic [31:0] d, prd; logic prdy;
      run_txn(0, 1'b0, 32'h20, 32'h12345678, cyc, d, prdy, prd);
      tests_run++; if (cyc !== 3) begin tests_failed++; $display("FAIL wr20_cycles: got %0d expected 3", cyc); end
      run_txn(0, 1'b1, 32'h23, 32'h0, cyc, d, prdy, prd);
      tests_run++; if (cyc !== 3) begin tests_failed++; $display("FAIL rd23_cycles: got %0d expected 3", cyc); end
      tests_run++; if (d !== 32'h12345678) begin tests_failed++; $display("FAIL rd23_data: got %h expected 12345678", d); end
      tests_run++; if (prd !== 32'h0) begin tests_failed++; $display("FAIL rd23_post_data: got %h expected 00000000", prd); end
   endtask

   task automatic test_back_to_back;
      int cyc; logic [31:0] d, prd; logic prdy;
      run_txn(1, 1'b0, 32'h40, 32'hCAFEF00D, cyc, d, prdy, prd);
      tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL b2b_w40_cycles: got %0d expected 1", cyc); end
      run_txn(1, 1'b1, 32'h40, 32'h0, cyc, d, prdy, prd);
      tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL b2b_r40_cycles: got %0d expected 1", cyc); end
      tests_run++; if (d !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL b2b_r40_data: got %h expected cafef00d", d); end
      run_txn(1, 1'b0, 32'h44, 32'h0BADF00D, cyc, d, prdy, prd);
      tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL b2b_w44_cycles: got %0d expected 1", cyc); end
      run_txn(1, 1'b1, 32'h44, 32'h0, cyc, d, prdy, prd);
      tests_run++; if (d !== 32'h0BADF00D) begin tests_failed++; $display("FAIL b2b_r44_data: got %h expected 0badf00d", d); end
      run_txn(1, 1'b1, 32'h40, 32'h0, cyc, d, prdy, prd);
      tests_run++; if (d !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL b2b_r40_again: got %h expected cafef00d", d); end
      tests_run++; if (prdy !== 1'b0) begin tests_failed++; $display("FAIL b2b_post_ready: got %b expected 0", prdy); end
   endtask

   task automatic test_abort;
      int cyc; logic [31:0] d, prd; logic prdy; bit seen;
      addr = 32'h0; write_data = 32'hFFFFFFFF; read_or_write = 1'b0; en2 = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      en2 = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clock); #1;
         if (rdy2 === 1'b1) seen = 1'b1;
      end
      tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL abort_ready_seen: got %b expected 0", seen); end
      run_txn(0, 1'b1, 32'h0, 32'h0, cyc, d, prdy, prd);
      tests_run++; if (d !== 32'hA5A50000) begin tests_failed++; $display("FAIL abort_mem0: got %h expected a5a50000", d); end
   endtask

   task automatic test_reset_mid;
      int cyc; logic [31:0] d, prd; logic prdy;
      addr = 32'h10; write_data = 32'h11111111; read_or_write = 1'b0; en2 = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      #2 reset = 1'b0;
      #1;
      tests_run++; if (rdy2 !== 1'b0) begin tests_failed++; $display("FAIL rstbusy_ready: got %b expected 0", rdy2); end
      tests_run++; if (rd2 !== 32'h0) begin tests_failed++; $display("FAIL rstbusy_data: got %h expected 00000000", rd2); end
      en2 = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      addr = 32'h10; read_or_write = 1'b1; en2 = 1'b1;
      cyc = -1;
      for (int i = 0; i <= 40 && cyc < 0; i++) begin
         @(posedge clock); #1;
         if (rdy2 === 1'b1) cyc = i;
      end
      tests_run++; if (rd2 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rstdone_pre_data: got %h expected deadbeef", rd2); end
      #3 reset = 1'b0;
      #1;
      tests_run++; if (rdy2 !== 1'b0) begin tests_failed++; $display("FAIL rstdone_ready: got %b expected 0", rdy2); end
      tests_run++; if (rd2 !== 32'h0) begin tests_failed++; $display("FAIL rstdone_data: got %h expected 00000000", rd2); end
      en2 = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      run_txn(0, 1'b1, 32'h10, 32'h0, cyc, d, prdy, prd);
      tests_run++; if (cyc !== 3) begin tests_failed++; $display("FAIL rst_fresh_cycles: got %0d expected 3", cyc); end
      tests_run++; if (d !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rst_fresh_data: got %h expected deadbeef", d); end
   endtask

   task automatic test_out_of_range;
      int cyc; logic [31:0] d, prd; logic prdy;
      run_txn(0, 1'b1, 32'h00001000, 32'h0, cyc, d, prdy, prd);
      tests_run++; if (cyc !== 3) begin tests_failed++; $display("FAIL oor_read_cycles: got %0d expected 3", cyc); end
      tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL oor_read_data: got %h expected 00000000", d); end
      run_txn(0, 1'b0, 32'h00001000, 32'h77777777, cyc, d, prdy, prd);
      tests_run++; if (cyc !== 3) begin tests_failed++; $display("FAIL oor_write_cycles: got %0d expected 3", cyc); end
      run_txn(0, 1'b1, 32'h0, 32'h0, cyc, d, prdy, prd);
      tests_run++; if (d !== 32'hA5A50000) begin tests_failed++; $display("FAIL oor_alias_mem0: got %h expected a5a50000", d); end
   endtask

   initial begin
      reset = 1'b0;
      en2 = 1'b0;
      en0 = 1'b0;
      addr = '0;
      write_data = '0;
      read_or_write = 1'b0;
      test_reset;
      test_preload;
      test_read_latency;
      test_write_read_low_bits;
      test_back_to_back;
      test_abort;
      test_reset_mid;
      test_out_of_range;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
